// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load/store size codes (funct3 encoding) and LSU state type.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } lsu_state_t;

    // Unused size codes fall into the word case, so they need full word alignment.
    function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            LDST_B, LDST_BU: return 1'b0;
            LDST_H, LDST_HU: return addr_lo[0];
            default:         return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and load extension.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] wd_rep,
    output logic [31:0] rd_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        be      = 4'b1111;
        wd_rep  = wd;
        rd_ext  = rd_word;
        rd_byte = rd_word[{addr_lo, 3'b000} +: 8];
        rd_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            LDST_B, LDST_BU: begin
                be     = 4'b0001 << addr_lo;
                wd_rep = {4{wd[7:0]}};
                rd_ext = (size == LDST_B) ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
            end
            LDST_H, LDST_HU: begin
                be     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{wd[15:0]}};
                rd_ext = (size == LDST_H) ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: one access at a time, stalls the core until the bus completes.
// Optional RISCV_LSU_MISALIGN_CHECK_EN rejects misaligned H/W accesses via misaligned_o.
module riscv_lsu
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
    ,
    output logic        misaligned_o
`endif
);

    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [31:0] core_rd_q;
    logic        legal;
    logic        accept;
    logic        in_wait;
    logic [3:0]  be;
    logic [31:0] wd_rep;
    logic [31:0] rd_ext;

`ifdef RISCV_LSU_MISALIGN_CHECK_EN
    assign legal        = !lsu_misaligned(core_size_i, core_addr_i[1:0]);
    assign misaligned_o = (state_q == IDLE) && core_req_i && !legal;
`else
    assign legal = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req_i && legal) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT:    if (mem_ready_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wd_q      <= '0;
            core_rd_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q   <= core_we_i;
                size_q <= core_size_i;
                addr_q <= core_addr_i;
                wd_q   <= core_wd_i;
            end
            if (in_wait && mem_ready_i && !we_q) core_rd_q <= rd_ext;
        end
    end

    riscv_lsu_align u_align (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .wd      (wd_q),
        .rd_word (mem_rd_i),
        .be      (be),
        .wd_rep  (wd_rep),
        .rd_ext  (rd_ext)
    );

    // Bus outputs are forced to zero outside WAIT so reset/idle values are all-zero.
    assign in_wait      = (state_q == WAIT);
    assign core_stall_o = accept || in_wait;
    assign mem_req_o    = in_wait;
    assign mem_we_o     = in_wait && we_q;
    assign mem_be_o     = in_wait ? be : '0;
    assign mem_addr_o   = in_wait ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wd_o     = in_wait ? wd_rep : '0;
    assign core_rd_o    = core_rd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: driver queues expected bus/load/stall behaviour, monitor compares.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr, core_wd, core_rd;
    logic        core_stall;
    logic        mem_req, mem_we, mem_ready;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd, mem_rd;
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    riscv_lsu dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready)
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
        ,
        .misaligned_o (misaligned)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } bus_t;

    typedef struct {
        logic stall;
        logic mis;
    } cyc_t;

    bus_t        bus_q[$];
    logic [31:0] ld_q[$];
    cyc_t        cq[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: size class 0 = byte, 1 = half, 2 = word.
    function automatic int kind(input logic [2:0] s);
        if (s == 3'd0 || s == 3'd4) return 0;
        if (s == 3'd1 || s == 3'd5) return 1;
        return 2;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] s, input logic [31:0] a);
        case (kind(s))
            0:       return 4'(1 << (a % 4));
            1:       return ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] s, input logic [31:0] wd);
        case (kind(s))
            0:       return (wd & 32'hFF) * 32'h01010101;
            1:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        case (kind(s))
            0: begin
                v = (rd >> (8 * (a % 4))) & 32'hFF;
                if (s == 3'd0 && v >= 32'd128) v = v | 32'hFFFFFF00;
            end
            1: begin
                v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
                if (s == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] s, input logic [31:0] a);
        case (kind(s))
            0:       return 1'b0;
            1:       return (a % 2) != 0;
            default: return (a % 4) != 0;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic stall, input logic mis);
        cyc_t c;
        c.stall = stall;
        c.mis   = mis;
        cq.push_back(c);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            next_cycle();
            core_req  = 1'b0;
            core_addr = $urandom;
            core_size = 3'($urandom);
            mem_ready = 1'($urandom);
            mem_rd    = $urandom;
            push(1'b0, 1'b0);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int unsigned dly);
        bus_t b;
        bit   ill;
        ill = 1'b0;
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
        ill = model_misaligned(size, addr);
`endif
        next_cycle();
        core_req  = 1'b1;
        core_we   = we;
        core_size = size;
        core_addr = addr;
        core_wd   = wd;
        mem_ready = 1'($urandom);
        mem_rd    = $urandom;
        if (ill) begin
            push(1'b0, 1'b1);
            next_cycle();
            core_req = 1'b0;
            push(1'b0, 1'b0);
            return;
        end
        b.addr = addr & ~32'h3;
        b.be   = model_be(size, addr);
        b.we   = we;
        b.wd   = model_wd(size, wd);
        bus_q.push_back(b);
        if (!we) ld_q.push_back(model_load(size, addr, rdata));
        push(1'b1, 1'b0);
        for (int unsigned k = 0; k <= dly; k++) begin
            next_cycle();
            mem_ready = (k == dly);
            mem_rd    = rdata;
            push(1'b1, 1'b0);
        end
        next_cycle();
        mem_ready = 1'($urandom);
        mem_rd    = $urandom;
        push(1'b0, 1'b0);
    endtask

    // Monitor: per-cycle stall/misaligned, bus contents during WAIT, load result and hold.
    initial begin
        cyc_t        c;
        bus_t        b;
        logic [31:0] last_rd = '0;
        bit          pending = 1'b0;
        forever begin
            @(negedge clk);
            if (cq.size() > 0) begin
                c = cq.pop_front();
                check("core_stall", 32'(core_stall), 32'(c.stall));
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
                check("misaligned", 32'(misaligned), 32'(c.mis));
`endif
            end
            if (!rst_n) begin
                last_rd = '0;
                pending = 1'b0;
            end
            if (pending) begin
                last_rd = ld_q.pop_front();
                pending = 1'b0;
            end
            check("core_rd", core_rd, last_rd);
            if (mem_req) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_mem_req", 32'(mem_req), 32'd0);
                end else begin
                    b = bus_q[0];
                    check("mem_addr", mem_addr, b.addr);
                    check("mem_be", 32'(mem_be), 32'(b.be));
                    check("mem_we", 32'(mem_we), 32'(b.we));
                    if (b.we) check("mem_wd", mem_wd, b.wd);
                    if (mem_ready) begin
                        void'(bus_q.pop_front());
                        if (!b.we) pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        core_req  = 1'b0;
        core_we   = 1'b0;
        core_size = '0;
        core_addr = '0;
        core_wd   = '0;
        mem_ready = 1'b0;
        mem_rd    = '0;
        #12;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_core_rd", core_rd, 32'd0);
        check("rst_stall", 32'(core_stall), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Directed cases from the feature list.
        issue(1'b1, 3'd2, 32'h0000_0104, 32'hDEADBEEF, 32'h0, 0);
        issue(1'b1, 3'd0, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0);
        issue(1'b0, 3'd0, 32'h0000_0001, 32'h0, 32'h0000_8000, 0);
        issue(1'b0, 3'd4, 32'h0000_0001, 32'h0, 32'h0000_8000, 1);
        issue(1'b0, 3'd5, 32'h0000_0002, 32'h0, 32'hBEEF_1234, 0);
        issue(1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'h1357_9BDF, 3);
        issue(1'b0, 3'd6, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 0);
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
        issue(1'b0, 3'd1, 32'h0000_0003, 32'h0, 32'h0, 0);
`endif
        idle(1);

        // Reset while a load is waiting on the bus.
        issue_reset_mid_wait();

        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        idle(3);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        check("ld_q_drained", 32'(ld_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic issue_reset_mid_wait();
        bus_t b;
        next_cycle();
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_size = 3'd2;
        core_addr = 32'h0000_0300;
        mem_ready = 1'b0;
        b.addr = 32'h0000_0300;
        b.be   = 4'hF;
        b.we   = 1'b0;
        b.wd   = '0;
        bus_q.push_back(b);
        ld_q.push_back(32'h0);
        push(1'b1, 1'b0);
        next_cycle();
        mem_ready = 1'b0;
        push(1'b1, 1'b0);
        next_cycle();
        core_req = 1'b0;
        rst_n    = 1'b0;
        push(1'b0, 1'b0);
        #1;
        check("rstwait_mem_req", 32'(mem_req), 32'd0);
        check("rstwait_stall", 32'(core_stall), 32'd0);
        bus_q.delete();
        ld_q.delete();
        next_cycle();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        mem_rd    = 32'hFFFF_FFFF;
        push(1'b0, 1'b0);
        idle(2);
    endtask

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load-store unit sitting between the core datapath and the data-memory bus; it is the responder to the memory-access controls produced by the main decoder (request, write-enable, access size). It accepts one access at a time, stalls the core until the bus completes, converts the byte/half/word access into a word-aligned bus transaction with byte enables, and returns sign- or zero-extended load data to writeback.

## Interface
Parameters: none. Widths are fixed by the RV32I datapath.

- clk_i  in  1  core clock
- rst_ni  in  1  reset, asynchronous, active-low
- core_req_i  in  1  memory access requested (decoder mem_req)
- core_we_i  in  1  1 = store, 0 = load (decoder mem_we)
- core_size_i  in  3  access size, LDST_B/H/W/BU/HU codes from riscv_pkg
- core_addr_i  in  32  byte address (ALU result)
- core_wd_i  in  32  store data (rs2)
- core_rd_o  out  32  extended load data
- core_stall_o  out  1  core must hold PC and instruction
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word-aligned bus address
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  bus read word
- mem_ready_i  in  1  bus access complete this cycle
- misaligned_o  out  1  only with RISCV_LSU_MISALIGN_CHECK_EN

## Operation
- FSM states IDLE, WAIT, DONE.
- IDLE: core_req_i=1 (and access legal) → capture we, size, addr, wd into registers; go WAIT. Otherwise stay.
- WAIT: mem_req_o=1, bus outputs driven from captured registers. mem_ready_i=1 → load: register extended read data into core_rd_q; go DONE. Else stay WAIT.
- DONE: unconditionally → IDLE; no acceptance in DONE (core_req_i still shows the completing instruction).
- core_stall_o = (IDLE & core_req_i & legal) | WAIT. Low in DONE.
- Byte enables: B/BU → 4'b0001 << addr[1:0]; H/HU → addr[1] ? 4'b1100 : 4'b0011; W → 4'b1111.
- mem_addr_o = {addr[31:2], 2'b00}. mem_wd_o: B → {4{wd[7:0]}}, H → {2{wd[15:0]}}, W → wd.
- Load extension: B/H sign-extend, BU/HU zero-extend the lane selected by addr[1:0] / addr[1]; W passes word.
- Size codes 3, 6, 7 treated as W.
- core_rd_o = core_rd_q; updated only on load completion, held otherwise.

## Timing
- Reset: state IDLE; all captured registers and core_rd_q 0; mem_req_o, mem_we_o, core_stall_o, misaligned_o 0; mem_be_o 0; mem_addr_o, mem_wd_o 0.
- Minimum latency: accept cycle N (stall=1), N+1 WAIT with mem_req_o=1 and mem_ready_i=1, N+2 DONE (stall=0, core_rd_o valid, writeback). Memory instruction occupies 3 cycles.
- Each extra cycle with mem_ready_i=0 in WAIT adds one stall cycle; bus outputs stable throughout WAIT.
- mem_ready_i outside WAIT is ignored.
- Async reset mid-WAIT: mem_req_o drops immediately; late response ignored.
- Back-to-back accesses: next request accepted earliest in cycle after DONE.

## Configuration
- RISCV_LSU_MISALIGN_CHECK_EN defined: H/HU with addr[0]=1 or W with addr[1:0]≠0 is illegal; in IDLE, misaligned_o=1 combinationally that cycle, no stall, no bus access, state stays IDLE.
- Undefined: port misaligned_o absent; low address bits beyond the size's alignment ignored (H uses addr[1], W ignores addr[1:0]); every request is legal.

## Structure
- riscv_pkg: existing LDST_* size codes; add lsu_state_t enum (IDLE, WAIT, DONE).
- Sub-module riscv_lsu_align: combinational byte-enable, store-replication and load-extension logic; top holds the FSM and registers.

## Test plan
- SW addr 0x104, wd 0xDEADBEEF, ready immediate → mem_addr 0x104, be 4'b1111, wd 0xDEADBEEF, stall 2 cycles.
- SB addr 0x203, wd 0x000000A5 → be 4'b1000, mem_wd 0xA5A5A5A5, mem_addr 0x200.
- LB addr 0x1, mem_rd 0x0000_8000 → core_rd 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x2, mem_rd 0xBEEF1234 → 0x0000BEEF.
- LW with mem_ready_i low 3 cycles → stall 5 cycles, bus outputs stable, core_rd valid only in DONE.
- rst_ni low during WAIT → mem_req_o, stall 0 immediately; after release, ready pulse ignored, state IDLE.
- With macro: LH addr 0x3 → misaligned_o 1, stall 0, mem_req_o stays 0.
